// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared sizing, types and helpers for the CDB writeback arbiter.
//   NUM_REQ  : number of FU requesters competing for the CDB
//   N_LANES  : CDB lanes broadcast per cycle
//   DATA_W   : result value width
//   PRN_W    : physical register tag width
//   ROBN_W   : ROB index width
//   cdb_packet_t : one CDB lane (valid, dest_prn, value, robn)
//   wrap_inc : modular +1 on a requester index (NUM_REQ need not be a power of two)
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int N_LANES = 2;
    localparam int DATA_W  = 32;
    localparam int PRN_W   = 6;
    localparam int ROBN_W  = 5;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(N_LANES + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic              valid;
        logic [PRN_W-1:0]  dest_prn;
        logic [DATA_W-1:0] value;
        logic [ROBN_W-1:0] robn;
    } cdb_packet_t;

    // Explicit wrap so a non power-of-two requester count never lands on an
    // index that does not exist.
    function automatic ptr_t wrap_inc(input ptr_t idx);
        if (idx == ptr_t'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + ptr_t'(1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the FU request side and the CDB broadcast side of the arbiter.
//   master : core/FU side -- drives squash and requests, sees grants and CDB
//   slave  : arbiter side -- sees requests, drives grants, CDB and grant count
// Signals:
//   squash                 ROB mispredict flush
//   req_valid/prn/value/robn  per-requester completed result
//   req_ready              per-requester grant
//   cdb_valid/prn/value/robn  per-lane registered broadcast
//   grant_cnt              grants issued this cycle
// -----------------------------------------------------------------------------
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                             squash;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0][PRN_W-1:0]    req_prn;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_value;
    logic [NUM_REQ-1:0][ROBN_W-1:0]   req_robn;
    logic [NUM_REQ-1:0]               req_ready;
    logic [N_LANES-1:0]               cdb_valid;
    logic [N_LANES-1:0][PRN_W-1:0]    cdb_prn;
    logic [N_LANES-1:0][DATA_W-1:0]   cdb_value;
    logic [N_LANES-1:0][ROBN_W-1:0]   cdb_robn;
    logic [CNT_W-1:0]                 grant_cnt;

    modport master (
        output squash, req_valid, req_prn, req_value, req_robn,
        input  req_ready, cdb_valid, cdb_prn, cdb_value, cdb_robn, grant_cnt
    );

    modport slave (
        input  squash, req_valid, req_prn, req_value, req_robn,
        output req_ready, cdb_valid, cdb_prn, cdb_value, cdb_robn, grant_cnt
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_rr_pick
// Rotating first-N-set picker. Starting at ptr and walking upward with wrap,
// the first N_LANES set bits of req_vec are granted.
//   req_vec   in  NUM_REQ            candidates
//   ptr       in  PTR_W              scan start index
//   grant     out NUM_REQ            one-hot-per-winner grant vector
//   lane_idx  out N_LANES x PTR_W    requester index packed into lane k
//   lane_used out N_LANES            lane k carries a winner
//   last_idx  out PTR_W              last winner in scan order
//   count     out CNT_W              number of winners
// -----------------------------------------------------------------------------
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]            req_vec,
    input  ptr_t                          ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [N_LANES-1:0][PTR_W-1:0] lane_idx,
    output logic [N_LANES-1:0]            lane_used,
    output ptr_t                          last_idx,
    output cnt_t                          count
);

    // Walk all requesters once in rotated order; the running winner count
    // doubles as the lane number, so lanes fill from 0 with no gaps.
    always_comb begin
        ptr_t idx;
        cnt_t n;
        grant     = '0;
        lane_idx  = '0;
        lane_used = '0;
        last_idx  = ptr;
        n         = '0;
        idx       = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_vec[idx] && (n < cnt_t'(N_LANES))) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < N_LANES; k++) begin
                    if (n == cnt_t'(k)) begin
                        lane_idx[k]  = idx;
                        lane_used[k] = 1'b1;
                    end
                end
                last_idx = idx;
                n        = n + cnt_t'(1);
            end
            idx = wrap_inc(idx);
        end
        count = n;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Writeback scheduler: each cycle grants up to N_LANES completed FU results in
// rotating priority order and broadcasts them, registered, on the CDB one
// cycle later.
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of cdb_arbiter_if (requests, grants, CDB, grant_cnt)
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    ptr_t                          ptr;
    logic [NUM_REQ-1:0]            pick_vec;
    logic [NUM_REQ-1:0]            grant;
    logic [N_LANES-1:0][PTR_W-1:0] lane_idx;
    logic [N_LANES-1:0]            lane_used;
    ptr_t                          last_idx;
    cnt_t                          count;
    cdb_packet_t [N_LANES-1:0]     lane_d;
    cdb_packet_t [N_LANES-1:0]     lane_q;

    // Masking the candidates (rather than the grants) keeps req_ready,
    // grant_cnt and the next-cycle CDB consistent under squash and reset.
    assign pick_vec = (reset && !bus.squash) ? bus.req_valid : '0;

    cdb_arbiter_rr_pick u_pick (
        .req_vec   (pick_vec),
        .ptr       (ptr),
        .grant     (grant),
        .lane_idx  (lane_idx),
        .lane_used (lane_used),
        .last_idx  (last_idx),
        .count     (count)
    );

    assign bus.req_ready = grant;
    assign bus.grant_cnt = count;

    // Steer each winner's result into its lane; unused lanes carry zeros.
    always_comb begin
        lane_d = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_used[k]) begin
                lane_d[k].valid    = 1'b1;
                lane_d[k].dest_prn = bus.req_prn[lane_idx[k]];
                lane_d[k].value    = bus.req_value[lane_idx[k]];
                lane_d[k].robn     = bus.req_robn[lane_idx[k]];
            end
        end
    end

    // Priority pointer moves past the last winner; squash restarts it at 0.
    // The output register is the only storage for granted data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
            if (bus.squash) begin
                ptr <= '0;
            end else if (count != '0) begin
                ptr <= wrap_inc(last_idx);
            end
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane_out
        assign bus.cdb_valid[k] = lane_q[k].valid;
        assign bus.cdb_prn[k]   = lane_q[k].dest_prn;
        assign bus.cdb_value[k] = lane_q[k].value;
        assign bus.cdb_robn[k]  = lane_q[k].robn;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed reset/fairness/wrap/sparse/
// squash/async-reset scenarios followed by randomized traffic, all compared
// against a queue-based reference of the rotating-priority rules.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock;
    logic reset;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: rotating start index and the lanes expected on the CDB.
    int                m_ptr;
    int                nxt_ptr;
    logic [NUM_REQ-1:0] exp_ready;
    int                exp_cnt;
    logic              exp_v    [N_LANES];
    logic [PRN_W-1:0]  exp_prn  [N_LANES];
    logic [DATA_W-1:0] exp_val  [N_LANES];
    logic [ROBN_W-1:0] exp_robn [N_LANES];
    logic              nxt_v    [N_LANES];
    logic [PRN_W-1:0]  nxt_prn  [N_LANES];
    logic [DATA_W-1:0] nxt_val  [N_LANES];
    logic [ROBN_W-1:0] nxt_robn [N_LANES];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something wedges the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0;
        for (int k = 0; k < N_LANES; k++) begin
            exp_v[k]    = 1'b0;
            exp_prn[k]  = '0;
            exp_val[k]  = '0;
            exp_robn[k] = '0;
        end
    endtask

    // Grants are the first N_LANES valid requesters seen while walking from
    // m_ptr around the ring; the k-th goes to lane k.
    task automatic modelSelect();
        int picked[$];
        picked    = {};
        exp_ready = '0;
        if (!bus.squash) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int idx;
                idx = (m_ptr + i) % NUM_REQ;
                if (bus.req_valid[idx] && picked.size() < N_LANES) picked.push_back(idx);
            end
        end
        foreach (picked[j]) exp_ready[picked[j]] = 1'b1;
        exp_cnt = picked.size();
        for (int k = 0; k < N_LANES; k++) begin
            if (k < picked.size()) begin
                nxt_v[k]    = 1'b1;
                nxt_prn[k]  = bus.req_prn[picked[k]];
                nxt_val[k]  = bus.req_value[picked[k]];
                nxt_robn[k] = bus.req_robn[picked[k]];
            end else begin
                nxt_v[k]    = 1'b0;
                nxt_prn[k]  = '0;
                nxt_val[k]  = '0;
                nxt_robn[k] = '0;
            end
        end
        if (bus.squash)             nxt_ptr = 0;
        else if (picked.size() > 0) nxt_ptr = (picked[picked.size()-1] + 1) % NUM_REQ;
        else                        nxt_ptr = m_ptr;
    endtask

    task automatic checkCdb(input string tag);
        for (int k = 0; k < N_LANES; k++) begin
            checkOutput($sformatf("%s_cdb_valid%0d", tag, k), 64'(bus.cdb_valid[k]), 64'(exp_v[k]));
            checkOutput($sformatf("%s_cdb_prn%0d", tag, k),   64'(bus.cdb_prn[k]),   64'(exp_prn[k]));
            checkOutput($sformatf("%s_cdb_value%0d", tag, k), 64'(bus.cdb_value[k]), 64'(exp_val[k]));
            checkOutput($sformatf("%s_cdb_robn%0d", tag, k),  64'(bus.cdb_robn[k]),  64'(exp_robn[k]));
        end
    endtask

    task automatic setFixedData();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_prn[i]   = PRN_W'(8'h10 + i);
            bus.req_value[i] = 32'hA000_0000 + 32'(i);
            bus.req_robn[i]  = ROBN_W'(i);
        end
    endtask

    task automatic applyStimulus(input logic sq, input logic [NUM_REQ-1:0] valid, input bit rand_data);
        bus.squash    = sq;
        bus.req_valid = valid;
        if (rand_data) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_prn[i]   = PRN_W'($urandom);
                bus.req_value[i] = $urandom;
                bus.req_robn[i]  = ROBN_W'($urandom);
            end
        end
    endtask

    // Called at a negedge with inputs already driven: checks the grant side,
    // crosses one rising edge, then checks what landed on the CDB.
    task automatic runCycle(input string tag);
        #1;
        modelSelect();
        checkOutput({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_ready));
        checkOutput({tag, "_grant_cnt"}, 64'(bus.grant_cnt), 64'(exp_cnt));
        @(posedge clock);
        m_ptr = nxt_ptr;
        for (int k = 0; k < N_LANES; k++) begin
            exp_v[k]    = nxt_v[k];
            exp_prn[k]  = nxt_prn[k];
            exp_val[k]  = nxt_val[k];
            exp_robn[k] = nxt_robn[k];
        end
        @(negedge clock);
        checkCdb(tag);
    endtask

    logic [NUM_REQ-1:0] fair_seq [5];

    initial begin
        fair_seq[0] = 8'h03;
        fair_seq[1] = 8'h0C;
        fair_seq[2] = 8'h30;
        fair_seq[3] = 8'hC0;
        fair_seq[4] = 8'h03;

        // Reset held with every requester valid: nothing may be granted.
        reset = 1'b0;
        setFixedData();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        modelReset();
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_ready", 64'(bus.req_ready), 64'h0);
        checkOutput("reset_grant_cnt", 64'(bus.grant_cnt), 64'h0);
        checkOutput("reset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Fairness: all valid, pairs rotate 0,1 -> 2,3 -> 4,5 -> 6,7 -> 0,1.
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 8'hFF, 1'b0);
            #1;
            checkOutput($sformatf("fair%0d_ready_const", j), 64'(bus.req_ready), 64'(fair_seq[j]));
            runCycle($sformatf("fair%0d", j));
            checkOutput($sformatf("fair%0d_lane0_const", j), 64'(bus.cdb_prn[0]), 64'(8'h10 + 2 * (j % 4)));
        end

        // Wrap: park the pointer at 7 with a lone req6, then 7 and 0 compete.
        applyStimulus(1'b0, 8'h40, 1'b0);
        runCycle("wrap_setup");
        applyStimulus(1'b0, 8'h81, 1'b0);
        #1;
        checkOutput("wrap_ready_const", 64'(bus.req_ready), 64'h81);
        runCycle("wrap");
        checkOutput("wrap_lane0_const", 64'(bus.cdb_prn[0]), 64'h17);
        checkOutput("wrap_lane1_const", 64'(bus.cdb_prn[1]), 64'h10);
        applyStimulus(1'b0, 8'hFF, 1'b0);
        #1;
        checkOutput("wrap_nextptr_const", 64'(bus.req_ready), 64'h06);
        runCycle("wrap_after");

        // Sparse: only req5 valid.
        bus.req_prn[5]   = 6'h2A;
        bus.req_value[5] = 32'hDEADBEEF;
        bus.req_robn[5]  = 5'd3;
        applyStimulus(1'b0, 8'h20, 1'b0);
        #1;
        checkOutput("sparse_ready_const", 64'(bus.req_ready), 64'h20);
        runCycle("sparse");
        checkOutput("sparse_valid_const", 64'(bus.cdb_valid), 64'h1);
        checkOutput("sparse_value_const", 64'(bus.cdb_value[0]), 64'hDEADBEEF);
        applyStimulus(1'b0, 8'hFF, 1'b0);
        #1;
        checkOutput("sparse_nextptr_const", 64'(bus.req_ready), 64'hC0);
        runCycle("sparse_after");

        // Squash: registered pair stays visible, nothing new granted, ptr -> 0.
        setFixedData();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        runCycle("pre_squash");
        applyStimulus(1'b1, 8'h0F, 1'b0);
        #1;
        checkOutput("squash_ready_const", 64'(bus.req_ready), 64'h0);
        checkOutput("squash_cnt_const", 64'(bus.grant_cnt), 64'h0);
        checkOutput("squash_held_valid_const", 64'(bus.cdb_valid), 64'h3);
        runCycle("squash");
        checkOutput("squash_next_valid_const", 64'(bus.cdb_valid), 64'h0);
        applyStimulus(1'b0, 8'hFF, 1'b0);
        #1;
        checkOutput("squash_ptr_const", 64'(bus.req_ready), 64'h03);
        runCycle("post_squash");

        // Randomized traffic with occasional squash.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 15) == 0), NUM_REQ'($urandom), 1'b1);
            runCycle($sformatf("rand%0d", c));
        end

        // Asynchronous reset between edges while the CDB is busy.
        applyStimulus(1'b0, 8'hFF, 1'b1);
        runCycle("pre_areset");
        applyStimulus(1'b0, 8'hFF, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        checkOutput("areset_ready", 64'(bus.req_ready), 64'h0);
        checkOutput("areset_grant_cnt", 64'(bus.grant_cnt), 64'h0);
        modelReset();
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            applyStimulus(($urandom_range(0, 15) == 0), NUM_REQ'($urandom), 1'b1);
            runCycle($sformatf("post_areset%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
